// File: rtl/command_frame_receiver.sv
// Byte-stream frame receiver: hunts for SYNC, assembles {SYNC,OPC,ARG,CHK}, emits checked opcode/arg pairs.
// Optional FRAME_STATS_EN adds saturating good_count/err_count outputs.
module command_frame_receiver #(
  parameter logic [7:0]  SYNC_BYTE      = 8'h7E,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  cmd_out,
  output logic [7:0]  arg_out,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        frame_err,
  output logic [1:0]  err_code
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0] good_count,
  output logic [15:0] err_count
`endif
);

  typedef enum logic [2:0] {S_HUNT, S_OPC, S_ARG, S_CHK, S_HOLD} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next;
  logic [15:0] r_timer;
  logic [7:0]  r_opc, r_arg;
  logic [7:0]  r_cmd, r_argo;
  logic        r_valid, r_ferr;
  logic [1:0]  r_ecode;
  logic        w_accept, w_busy, w_tmo;
  logic        w_good, w_abort_to, w_abort_ck;
  logic [7:0]  w_sum;

  assign rx_ready = (r_state != S_HOLD);
  assign w_accept = rx_valid && rx_ready;
  assign w_busy   = (r_state == S_OPC) || (r_state == S_ARG) || (r_state == S_CHK);
  assign w_tmo    = w_busy && !w_accept && (r_timer == TMO_LAST);
  assign w_sum    = r_opc + r_arg;

  always_comb begin
    w_next     = r_state;
    w_good     = 1'b0;
    w_abort_to = 1'b0;
    w_abort_ck = 1'b0;
    case (r_state)
      S_HUNT: if (w_accept && rx_data == SYNC_BYTE) w_next = S_OPC;
      S_OPC: begin
        if (w_accept)   w_next = S_ARG;
        else if (w_tmo) begin w_next = S_HUNT; w_abort_to = 1'b1; end
      end
      S_ARG: begin
        if (w_accept)   w_next = S_CHK;
        else if (w_tmo) begin w_next = S_HUNT; w_abort_to = 1'b1; end
      end
      S_CHK: begin
        if (w_accept) begin
          if (rx_data == w_sum) begin w_next = S_HOLD; w_good = 1'b1; end
          else begin w_next = S_HUNT; w_abort_ck = 1'b1; end
        end else if (w_tmo) begin
          w_next = S_HUNT; w_abort_to = 1'b1;
        end
      end
      S_HOLD: if (cmd_ready) w_next = S_HUNT;
      default: w_next = S_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_HUNT;
      r_timer <= '0;
      r_valid <= 1'b0;
      r_cmd   <= '0;
      r_argo  <= '0;
      r_ferr  <= 1'b0;
      r_ecode <= 2'b00;
    end else begin
      r_state <= w_next;
      // Timer restarts on any accepted byte, so entering OPC also clears it
      r_timer <= (w_busy && !w_accept && !w_tmo) ? r_timer + 16'd1 : 16'd0;
      r_ferr  <= w_abort_to || w_abort_ck;
      if (w_abort_to) r_ecode <= 2'b01;
      if (w_abort_ck) r_ecode <= 2'b10;
      if (w_good) begin
        r_valid <= 1'b1;
        r_cmd   <= r_opc;
        r_argo  <= r_arg;
      end else if (r_valid && cmd_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && r_state == S_OPC) r_opc <= rx_data;
    if (w_accept && r_state == S_ARG) r_arg <= rx_data;
  end

  assign cmd_out   = r_cmd;
  assign arg_out   = r_argo;
  assign cmd_valid = r_valid;
  assign frame_err = r_ferr;
  assign err_code  = r_ecode;

`ifdef FRAME_STATS_EN
  logic [15:0] r_good_cnt, r_err_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_good_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (r_valid && cmd_ready) r_good_cnt <= sat_inc(r_good_cnt);
      if (r_ferr)               r_err_cnt  <= sat_inc(r_err_cnt);
    end
  end

  assign good_count = r_good_cnt;
  assign err_count  = r_err_cnt;
`endif

endmodule

// File: tb/tb_command_frame_receiver.sv
// Directed bench for command_frame_receiver (TIMEOUT_CYCLES overridden to 8).
module tb_command_frame_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  cmd_out, arg_out;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        frame_err;
  logic [1:0]  err_code;
`ifdef FRAME_STATS_EN
  logic [15:0] good_count, err_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  command_frame_receiver #(.SYNC_BYTE(8'h7E), .TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .cmd_out   (cmd_out),
    .arg_out   (arg_out),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .frame_err (frame_err),
    .err_code  (err_code)
`ifdef FRAME_STATS_EN
    ,
    .good_count(good_count),
    .err_count (err_count)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after an edge; return just after the next edge.
  task automatic cyc(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cmd_ready = 1'b1;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", {15'd0, cmd_valid}, 16'd0);
    chk("rst_rx_ready", {15'd0, rx_ready}, 16'd1);
    chk("rst_err_code", {14'd0, err_code}, 16'd0);
    chk("rst_cmd_out", {8'd0, cmd_out}, 16'd0);

    // Good frame
    cyc(1, 8'h7E); cyc(1, 8'h3C); cyc(1, 8'h10);
    chk("t1_no_valid_early", {15'd0, cmd_valid}, 16'd0);
    cyc(1, 8'h4C);
    chk("t1_valid", {15'd0, cmd_valid}, 16'd1);
    chk("t1_cmd", {8'd0, cmd_out}, 16'h3C);
    chk("t1_arg", {8'd0, arg_out}, 16'h10);
    chk("t1_ferr", {15'd0, frame_err}, 16'd0);
    chk("t1_rx_ready_hold", {15'd0, rx_ready}, 16'd0);
    cyc(0, 8'h00);
    chk("t1_valid_drop", {15'd0, cmd_valid}, 16'd0);
    chk("t1_rx_ready_back", {15'd0, rx_ready}, 16'd1);

    // Bad checksum, then a good frame
    cyc(1, 8'h7E); cyc(1, 8'h3C); cyc(1, 8'h10); cyc(1, 8'h4D);
    chk("t2_ferr", {15'd0, frame_err}, 16'd1);
    chk("t2_code", {14'd0, err_code}, 16'd2);
    chk("t2_no_valid", {15'd0, cmd_valid}, 16'd0);
    chk("t2_cmd_kept", {8'd0, cmd_out}, 16'h3C);
    cyc(1, 8'h7E);
    chk("t2_ferr_pulse", {15'd0, frame_err}, 16'd0);
    cyc(1, 8'h01); cyc(1, 8'h02); cyc(1, 8'h03);
    chk("t2_valid", {15'd0, cmd_valid}, 16'd1);
    chk("t2_cmd", {8'd0, cmd_out}, 16'h01);
    chk("t2_arg", {8'd0, arg_out}, 16'h02);
    chk("t2_code_held", {14'd0, err_code}, 16'd2);
    cyc(0, 8'h00);

    // Hunt through garbage
    cyc(1, 8'h00); chk("t3_ferr0", {15'd0, frame_err}, 16'd0);
    cyc(1, 8'hFF); chk("t3_ferr1", {15'd0, frame_err}, 16'd0);
    cyc(1, 8'hA5); chk("t3_ferr2", {15'd0, frame_err}, 16'd0);
    cyc(1, 8'h7E); cyc(1, 8'hA5); cyc(1, 8'h00);
    chk("t3_no_valid_early", {15'd0, cmd_valid}, 16'd0);
    cyc(1, 8'hA5);
    chk("t3_valid", {15'd0, cmd_valid}, 16'd1);
    chk("t3_cmd", {8'd0, cmd_out}, 16'hA5);
    chk("t3_arg", {8'd0, arg_out}, 16'h00);
    cyc(0, 8'h00);
    chk("t3_single_valid", {15'd0, cmd_valid}, 16'd0);

    // Backpressure
    cmd_ready = 1'b0;
    cyc(1, 8'h7E); cyc(1, 8'h11); cyc(1, 8'h22); cyc(1, 8'h33);
    chk("t4_valid", {15'd0, cmd_valid}, 16'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'h7E);
      chk("t4_hold_valid", {15'd0, cmd_valid}, 16'd1);
      chk("t4_hold_cmd", {8'd0, cmd_out}, 16'h11);
      chk("t4_hold_arg", {8'd0, arg_out}, 16'h22);
      chk("t4_hold_rx_ready", {15'd0, rx_ready}, 16'd0);
    end
    cmd_ready = 1'b1;
    cyc(0, 8'h00);
    chk("t4_release_valid", {15'd0, cmd_valid}, 16'd0);
    chk("t4_release_rx_ready", {15'd0, rx_ready}, 16'd1);
    cyc(1, 8'h01); cyc(1, 8'h02); cyc(1, 8'h03);
    chk("t4_hold_bytes_not_sync", {15'd0, cmd_valid}, 16'd0);

    // Timeout on the 8th idle cycle
    cyc(1, 8'h7E); cyc(1, 8'h3C);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 8'h00);
      chk("t5_no_early_tmo", {15'd0, frame_err}, 16'd0);
    end
    cyc(0, 8'h00);
    chk("t5_tmo_ferr", {15'd0, frame_err}, 16'd1);
    chk("t5_tmo_code", {14'd0, err_code}, 16'd1);
    cyc(0, 8'h00);
    chk("t5_tmo_pulse", {15'd0, frame_err}, 16'd0);
    // Byte arriving on the 8th idle cycle wins
    cyc(1, 8'h7E); cyc(1, 8'h3C);
    for (int i = 0; i < 7; i++) cyc(0, 8'h00);
    cyc(1, 8'h10);
    chk("t5_byte_wins", {15'd0, frame_err}, 16'd0);
    cyc(1, 8'h4C);
    chk("t5_valid", {15'd0, cmd_valid}, 16'd1);
    chk("t5_cmd", {8'd0, cmd_out}, 16'h3C);
    cyc(0, 8'h00);

    // Asynchronous reset mid-frame
    cyc(1, 8'h7E); cyc(1, 8'h3C);
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {15'd0, cmd_valid}, 16'd0);
    chk("t6_rst_cmd", {8'd0, cmd_out}, 16'h00);
    chk("t6_rst_arg", {8'd0, arg_out}, 16'h00);
    chk("t6_rst_code", {14'd0, err_code}, 16'd0);
    chk("t6_rst_ferr", {15'd0, frame_err}, 16'd0);
    chk("t6_rst_rx_ready", {15'd0, rx_ready}, 16'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1, 8'h7E); cyc(1, 8'h11); cyc(1, 8'h22); cyc(1, 8'h33);
    chk("t6_valid", {15'd0, cmd_valid}, 16'd1);
    chk("t6_cmd", {8'd0, cmd_out}, 16'h11);
    chk("t6_arg", {8'd0, arg_out}, 16'h22);
    cyc(0, 8'h00);
`ifdef FRAME_STATS_EN
    chk("t6_good_count", good_count, 16'd1);
    chk("t6_err_count", err_count, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
